// File: rtl/sram_arb_pkg.sv
// Shared constants for the SRAM port arbiter: FSM encoding, grant IDs and default widths.
package sram_arb_pkg;

    localparam int MEMORY_DATA_WIDTH_DEF = 8;
    localparam int MEMORY_ADDR_WIDTH_DEF = 9;

    localparam logic ARB_IDLE   = 1'b0;
    localparam logic ARB_ACCESS = 1'b1;

    // Grant IDs double as bit positions in the arbiter request vector.
    localparam logic GNT_LD  = 1'b0;
    localparam logic GNT_CPU = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker; on contention it favours the port not granted last.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = GNT_LD;
        if (&req) begin
            gnt_id = ~last_gnt;
        end else if (req[GNT_CPU]) begin
            gnt_id = GNT_CPU;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between the serial loader (write-only) and the CPU port,
// issuing each access as a one-cycle registered strobe followed by a return to idle.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int MEMORY_DATA_WIDTH = MEMORY_DATA_WIDTH_DEF,
    parameter int MEMORY_ADDR_WIDTH = MEMORY_ADDR_WIDTH_DEF
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         BOOT,
    input  logic                         LD_REQ,
    input  logic [MEMORY_ADDR_WIDTH-1:0] LD_A,
    input  logic [MEMORY_DATA_WIDTH-1:0] LD_D,
    output logic                         LD_ACK,
    input  logic                         CPU_REQ,
    input  logic                         CPU_WE,
    input  logic [MEMORY_ADDR_WIDTH-1:0] CPU_A,
    input  logic [MEMORY_DATA_WIDTH-1:0] CPU_D,
    output logic                         CPU_ACK,
    output logic [MEMORY_DATA_WIDTH-1:0] CPU_Q,
    output logic                         CPU_QV,
    output logic                         SRAM_CEN,
    output logic                         SRAM_WEN,
    output logic [MEMORY_ADDR_WIDTH-1:0] SRAM_A,
    output logic [MEMORY_DATA_WIDTH-1:0] SRAM_D,
    input  logic [MEMORY_DATA_WIDTH-1:0] SRAM_Q
);

    logic                         state_q,    state_d;
    logic                         last_gnt_q, last_gnt_d;
    logic                         cen_q,      cen_d;
    logic                         wen_q,      wen_d;
    logic [MEMORY_ADDR_WIDTH-1:0] a_q,        a_d;
    logic [MEMORY_DATA_WIDTH-1:0] d_q,        d_d;
    logic                         ld_ack_q,   ld_ack_d;
    logic                         cpu_ack_q,  cpu_ack_d;
    logic                         qv_q,       qv_d;

    logic [1:0] req_vec;
    logic       gnt_valid;
    logic       gnt_id;

    // BOOT masks the CPU before arbitration, so it never influences fairness state.
    assign req_vec = {CPU_REQ & ~BOOT, LD_REQ};

    rr_arb2 u_rr_arb2 (
        .req       (req_vec),
        .last_gnt  (last_gnt_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        cen_d      = 1'b1;
        wen_d      = 1'b1;
        a_d        = a_q;
        d_d        = d_q;
        ld_ack_d   = 1'b0;
        cpu_ack_d  = 1'b0;
        qv_d       = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (gnt_valid) begin
                    state_d = ARB_ACCESS;
                    cen_d   = 1'b0;
                    if (&req_vec) begin
                        last_gnt_d = gnt_id;
                    end
                    if (gnt_id == GNT_LD) begin
                        wen_d    = 1'b0;
                        a_d      = LD_A;
                        d_d      = LD_D;
                        ld_ack_d = 1'b1;
                    end else begin
                        wen_d     = ~CPU_WE;
                        a_d       = CPU_A;
                        d_d       = CPU_D;
                        cpu_ack_d = 1'b1;
                    end
                end
            end
            default: begin
                // Data from a CPU read strobe arrives on SRAM_Q one cycle after the strobe.
                state_d = ARB_IDLE;
                qv_d    = cpu_ack_q & wen_q;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ARB_IDLE;
            last_gnt_q <= GNT_CPU;
            cen_q      <= 1'b1;
            wen_q      <= 1'b1;
            a_q        <= '0;
            d_q        <= '0;
            ld_ack_q   <= 1'b0;
            cpu_ack_q  <= 1'b0;
            qv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cen_q      <= cen_d;
            wen_q      <= wen_d;
            a_q        <= a_d;
            d_q        <= d_d;
            ld_ack_q   <= ld_ack_d;
            cpu_ack_q  <= cpu_ack_d;
            qv_q       <= qv_d;
        end
    end

    assign SRAM_CEN = cen_q;
    assign SRAM_WEN = wen_q;
    assign SRAM_A   = a_q;
    assign SRAM_D   = d_q;
    assign LD_ACK   = ld_ack_q;
    assign CPU_ACK  = cpu_ack_q;
    assign CPU_QV   = qv_q;
    assign CPU_Q    = SRAM_Q;

endmodule
